// File: rtl/led_activity_ctrl_pkg.sv
// Shared mode encodings and elaboration helpers for the LED activity controller.
// Pure definitions, no logic; no flow control involved.
package led_activity_ctrl_pkg;

  typedef enum logic [1:0] {
    LED_OFF     = 2'd0,
    LED_ON      = 2'd1,
    LED_BLINK   = 2'd2,
    LED_STRETCH = 2'd3
  } led_mode_e;

  // Minimum width is 1 so a value of 1 still yields a usable register.
  function automatic int clog2(input int value);
    int width;
    width = 0;
    for (int k = 0; k < 32; k++) begin
      if ((64'd1 << width) < 64'(value)) width = width + 1;
    end
    return (width < 1) ? 1 : width;
  endfunction

endpackage

// File: rtl/led_stretch_ch.sv
// One LED channel: optional synchroniser, rising-edge detect, stretch counter, output mux.
// LED is registered; EVENT-to-LED latency is 3 cycles with SYNC=1, 1 with SYNC=0; never stalls.
module led_stretch_ch
  import led_activity_ctrl_pkg::*;
#(
  parameter int   STRETCH = 3,
  parameter int   SYNC    = 1,
  parameter int   SCW     = 2,
  parameter logic INV     = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] mode_i,
  input  logic       event_i,
  input  logic       tick_i,
  input  logic       blink_i,
  output logic       led_o
);

  logic           ev_s;
  logic           prev_q;
  logic           evt_edge;
  logic [SCW-1:0] sc_q, sc_d;
  logic           led_q, led_d;
  led_mode_e      mode;

  if (SYNC != 0) begin : g_sync
    logic s1_q, s2_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        s1_q <= 1'b0;
        s2_q <= 1'b0;
      end else begin
        s1_q <= event_i;
        s2_q <= s1_q;
      end
    end
    assign ev_s = s2_q;
  end else begin : g_nosync
    assign ev_s = event_i;
  end

  assign mode     = led_mode_e'(mode_i);
  assign evt_edge = ev_s & ~prev_q;

  // Edge load beats a coincident tick decrement, so a retrigger never loses time.
  always_comb begin
    sc_d = sc_q;
    if (mode != LED_STRETCH) begin
      sc_d = '0;
    end else if (evt_edge) begin
      sc_d = SCW'(STRETCH);
    end else if (tick_i && (sc_q != '0)) begin
      sc_d = sc_q - SCW'(1);
    end
  end

  // Stretch uses the next counter value so the LED lights in the same edge as the load.
  always_comb begin
    led_d = 1'b0;
    case (mode)
      LED_OFF:     led_d = 1'b0;
      LED_ON:      led_d = 1'b1;
      LED_BLINK:   led_d = blink_i;
      LED_STRETCH: led_d = (sc_d != '0);
      default:     led_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= 1'b0;
      sc_q   <= '0;
      led_q  <= INV;
    end else begin
      prev_q <= ev_s;
      sc_q   <= sc_d;
      led_q  <= led_d ^ INV;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/led_activity_ctrl.sv
// Front-panel LED / test-point driver: shared prescaler and heartbeat, NCH mode-selectable channels.
// LED registered (1 cycle after MODE, 1 or 3 cycles after EVENT); no backpressure, runs every cycle.
module led_activity_ctrl
  import led_activity_ctrl_pkg::*;
#(
  parameter int             NCH      = 4,
  parameter int             PRESCALE = 2**23,
  parameter int             HBW      = 4,
  parameter int             STRETCH  = 3,
  parameter int             SYNC     = 1,
  parameter logic [NCH-1:0] INVERT   = {NCH{1'b0}}
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [2*NCH-1:0] MODE,
  input  logic [NCH-1:0]   EVENT,
  output logic [NCH-1:0]   LED,
  output logic             TICK,
  output logic [HBW-1:0]   HBCNT
);

  localparam int PW  = clog2(PRESCALE);
  localparam int SCW = clog2(STRETCH + 1);

  logic [PW-1:0]  pre_q, pre_d;
  logic           tick_q, tick_d;
  logic [HBW-1:0] hb_q, hb_d;
  logic           pre_wrap;

  assign pre_wrap = (pre_q == PW'(PRESCALE - 1));

  // Heartbeat steps on the same edge that raises TICK, so HBCNT is already new while TICK is high.
  always_comb begin
    pre_d  = pre_wrap ? '0 : pre_q + PW'(1);
    tick_d = pre_wrap;
    hb_d   = pre_wrap ? hb_q + HBW'(1) : hb_q;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
      hb_q   <= '0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
      hb_q   <= hb_d;
    end
  end

  assign TICK  = tick_q;
  assign HBCNT = hb_q;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    led_stretch_ch #(
      .STRETCH (STRETCH),
      .SYNC    (SYNC),
      .SCW     (SCW),
      .INV     (INVERT[i])
    ) u_ch (
      .clk_i   (CLK),
      .rst_ni  (RST_N),
      .mode_i  (MODE[2*i +: 2]),
      .event_i (EVENT[i]),
      .tick_i  (tick_q),
      .blink_i (hb_q[HBW-1]),
      .led_o   (LED[i])
    );
  end

endmodule
